simple_hella_cache_if: RTL and testbench
========================================

SIMPLE_HELLA_CACHE_IF -- requirements
Module: simple_hella_cache_if

Interface
REQ-001 SHALL have parameters: ADDR_W default 32, byte address width; DATA_W default 32, data width; TAG_W default 9, request tag width.
REQ-002 SHALL have port clk, in, 1, the single clock; all state updates on rising edge.
REQ-003 SHALL have port reset, in, 1, synchronous active-high reset.
REQ-004 SHALL have client request ports: io_client_req_ready out 1; io_client_req_valid in 1; io_client_req_bits_addr in ADDR_W; _tag in TAG_W; _cmd in 5; _typ in 3; _phys in 1; _data in DATA_W (store data, presented with the request).
REQ-005 SHALL have client response ports: io_client_resp_valid out 1; io_client_resp_bits_tag out TAG_W; _data out DATA_W; _has_data out 1; io_client_busy out 1 (replay buffer non-empty or s1/s2 occupied).
REQ-006 SHALL have cache-side ports matching the arbiter requestor port: io_cache_req_ready in 1; io_cache_req_valid out 1; io_cache_req_bits_addr/_tag/_cmd/_typ/_phys out; io_cache_s1_kill out 1; io_cache_s1_data out DATA_W; io_cache_s2_nack in 1; io_cache_resp_valid in 1; io_cache_resp_bits_tag/_data/_has_data/_replay in.

Function
REQ-007 SHALL issue to the cache combinationally: io_cache_req_valid = replay head valid, else io_client_req_valid; replay head takes strict priority over the client.
REQ-008 SHALL drive io_client_req_ready = io_cache_req_ready AND replay buffer empty AND NOT (s2 valid AND io_cache_s2_nack).
REQ-009 SHALL hold a request "fired" when io_cache_req_valid AND io_cache_req_ready; the fired request (all fields incl. data) SHALL be captured in stage-s1 register with s1_valid=1 next cycle.
REQ-010 SHALL drive io_cache_s1_data from the s1 data field every cycle, so store data lags the request by exactly one cycle.
REQ-011 SHALL advance s1 into stage-s2 each cycle (s2_valid <= s1_valid AND NOT io_cache_s1_kill); s2 is not valid if s1 was killed.
REQ-012 SHALL, when s2_valid AND io_cache_s2_nack, push the s2 request into the replay buffer and assert io_cache_s1_kill the same cycle if s1_valid; the killed s1 request SHALL be pushed immediately after the s2 entry (same cycle, two pushes) so program order is kept.
REQ-013 SHALL drive io_cache_s1_kill = 0 in all other cycles; io_cache_s2_nack with s2_valid=0 SHALL be ignored.
REQ-014 SHALL implement the replay buffer as a 2-entry FIFO (ring, wrap-around pointers, count 0..2); pop on fire of the head; simultaneous pop and push SHALL be legal and preserve order.
REQ-015 SHALL, if a nack arrives while a replay entry fires the same cycle, push the nacked entries ahead of remaining entries only if buffer is otherwise empty; otherwise behind the fired head's successor (strict age order); overflow SHALL be impossible because client acceptance stops while buffer non-empty (assertion: count never exceeds 2).
REQ-016 SHALL forward io_cache_resp_* to io_client_resp_* with zero latency, except io_client_resp_valid = io_cache_resp_valid AND NOT io_cache_resp_bits_replay.
REQ-017 SHALL drive io_client_busy = s1_valid OR s2_valid OR count != 0.

Reset
REQ-018 SHALL, on reset, clear s1_valid, s2_valid, FIFO pointers and count; io_cache_req_valid, io_cache_s1_kill, io_client_resp_valid (if cache idle) and io_client_busy SHALL read 0 the cycle after reset; data fields need no reset.
REQ-019 SHALL discard all in-flight and buffered requests when reset asserts mid-operation; no replay after reset deasserts.

Structure
REQ-020 SHALL place cmd/typ encodings (M_XRD=5'h00, M_XWR=5'h01, MT_W=3'h2) and the request record field widths in the shared cache package.
REQ-021 SHALL implement the replay FIFO as one sub-module, hella_replay_queue (depth 2, dual push port).

Verification
REQ-022 Single load addr 0x1000 tag 0x05, cache ready, no nack -> cache req same cycle, resp tag 0x05 forwarded; busy 0 two cycles after resp stage.
REQ-023 Store addr 0x2000 data 0xDEADBEEF -> io_cache_s1_data=0xDEADBEEF exactly one cycle after fire.
REQ-024 Back-to-back loads tags 1,2; nack on tag 1 in s2 -> s1_kill asserted same cycle, replays reissue tag 1 then tag 2, client_req_ready low until buffer empty.
REQ-025 Replayed request nacked again -> re-pushed, reissued; order 1 then 2 preserved; count never >2.
REQ-026 resp_valid with replay=1 -> io_client_resp_valid=0; io_cache_req_ready=0 for 5 cycles -> no fire, s1_valid stays 0.
REQ-027 Reset asserted with 2 entries buffered -> next cycle io_cache_req_valid=0, busy=0, no replay after release.

Source files
------------

// File: rtl/simple_hella_cache_if_pkg.sv
// Shared cache definitions: memory command/type encodings and request record layout.
// Also provides a helper that sizes the packed request record.
package simple_hella_cache_if_pkg;

    localparam int CMD_W  = 5;
    localparam int TYP_W  = 3;
    localparam int PHYS_W = 1;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_TAG_W  = 9;

    localparam int REPLAY_DEPTH = 2;

    localparam logic [CMD_W-1:0] M_XRD = 5'h00;
    localparam logic [CMD_W-1:0] M_XWR = 5'h01;
    localparam logic [TYP_W-1:0] MT_W  = 3'h2;

    // Packed request record, MSB first: {addr, tag, cmd, typ, phys, data}
    function automatic int req_rec_w(input int addr_w, input int tag_w, input int data_w);
        return addr_w + tag_w + CMD_W + TYP_W + PHYS_W + data_w;
    endfunction

endpackage

// File: rtl/simple_hella_cache_if_if.sv
// Client and cache-side handshake bundle of the simple hella cache adapter.
// The slave modport is the adapter's view and the master modport is the environment's view.
interface simple_hella_cache_if_if
    import simple_hella_cache_if_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int TAG_W  = DEF_TAG_W
);
    logic              io_client_req_ready;
    logic              io_client_req_valid;
    logic [ADDR_W-1:0] io_client_req_bits_addr;
    logic [TAG_W-1:0]  io_client_req_bits_tag;
    logic [CMD_W-1:0]  io_client_req_bits_cmd;
    logic [TYP_W-1:0]  io_client_req_bits_typ;
    logic              io_client_req_bits_phys;
    logic [DATA_W-1:0] io_client_req_bits_data;

    logic              io_client_resp_valid;
    logic [TAG_W-1:0]  io_client_resp_bits_tag;
    logic [DATA_W-1:0] io_client_resp_bits_data;
    logic              io_client_resp_bits_has_data;
    logic              io_client_busy;

    logic              io_cache_req_ready;
    logic              io_cache_req_valid;
    logic [ADDR_W-1:0] io_cache_req_bits_addr;
    logic [TAG_W-1:0]  io_cache_req_bits_tag;
    logic [CMD_W-1:0]  io_cache_req_bits_cmd;
    logic [TYP_W-1:0]  io_cache_req_bits_typ;
    logic              io_cache_req_bits_phys;
    logic              io_cache_s1_kill;
    logic [DATA_W-1:0] io_cache_s1_data;
    logic              io_cache_s2_nack;
    logic              io_cache_resp_valid;
    logic [TAG_W-1:0]  io_cache_resp_bits_tag;
    logic [DATA_W-1:0] io_cache_resp_bits_data;
    logic              io_cache_resp_bits_has_data;
    logic              io_cache_resp_bits_replay;

    modport slave (
        output io_client_req_ready,
        input  io_client_req_valid, io_client_req_bits_addr, io_client_req_bits_tag,
               io_client_req_bits_cmd, io_client_req_bits_typ, io_client_req_bits_phys,
               io_client_req_bits_data,
        output io_client_resp_valid, io_client_resp_bits_tag, io_client_resp_bits_data,
               io_client_resp_bits_has_data, io_client_busy,
        input  io_cache_req_ready,
        output io_cache_req_valid, io_cache_req_bits_addr, io_cache_req_bits_tag,
               io_cache_req_bits_cmd, io_cache_req_bits_typ, io_cache_req_bits_phys,
               io_cache_s1_kill, io_cache_s1_data,
        input  io_cache_s2_nack, io_cache_resp_valid, io_cache_resp_bits_tag,
               io_cache_resp_bits_data, io_cache_resp_bits_has_data, io_cache_resp_bits_replay
    );

    modport master (
        input  io_client_req_ready,
        output io_client_req_valid, io_client_req_bits_addr, io_client_req_bits_tag,
               io_client_req_bits_cmd, io_client_req_bits_typ, io_client_req_bits_phys,
               io_client_req_bits_data,
        input  io_client_resp_valid, io_client_resp_bits_tag, io_client_resp_bits_data,
               io_client_resp_bits_has_data, io_client_busy,
        output io_cache_req_ready,
        input  io_cache_req_valid, io_cache_req_bits_addr, io_cache_req_bits_tag,
               io_cache_req_bits_cmd, io_cache_req_bits_typ, io_cache_req_bits_phys,
               io_cache_s1_kill, io_cache_s1_data,
        output io_cache_s2_nack, io_cache_resp_valid, io_cache_resp_bits_tag,
               io_cache_resp_bits_data, io_cache_resp_bits_has_data, io_cache_resp_bits_replay
    );

endinterface

// File: rtl/simple_hella_cache_if_chk.sv
// Property checker for the adapter's replay buffer and kill signalling.
module simple_hella_cache_if_chk (
    input logic       clk,
    input logic       reset,
    input logic [1:0] count,
    input logic       s1_kill,
    input logic       s1_valid
);
    // The replay buffer must never be asked to hold more than two entries.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (count != 2'd3);
            assert (!s1_kill || s1_valid);
        end
    end
endmodule

// File: rtl/simple_hella_cache_if_replay_queue.sv
// Two-entry replay ring buffer with two ordered push ports and one pop port.
// New entries always land behind whatever survives this cycle's pop, push0 before push1.
module hella_replay_queue
    import simple_hella_cache_if_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push0_valid,
    input  logic [W-1:0] push0_data,
    input  logic         push1_valid,
    input  logic [W-1:0] push1_data,
    input  logic         pop,
    output logic         head_valid,
    output logic [W-1:0] head_data,
    output logic [1:0]   count
);
    logic [W-1:0] mem_r [REPLAY_DEPTH];
    logic         head_ptr_r;
    logic [1:0]   count_r;
    logic         tail_s;
    logic         pop_s;
    logic [2:0]   count_next_s;

    // Tail slot is unaffected by a pop, so pushes can index it directly.
    always_comb begin
        pop_s        = pop & (count_r != 2'd0);
        tail_s       = head_ptr_r ^ count_r[0];
        count_next_s = {1'b0, count_r} - {2'b00, pop_s}
                     + {2'b00, push0_valid} + {2'b00, push1_valid};
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_ptr_r <= 1'b0;
            count_r    <= 2'd0;
        end else begin
            head_ptr_r <= head_ptr_r ^ pop_s;
            count_r    <= count_next_s[1:0];
        end
    end

    // Entry storage; contents are meaningless while the slot is unoccupied.
    always_ff @(posedge clk) begin
        if (push0_valid) begin
            mem_r[tail_s] <= push0_data;
        end
        if (push1_valid) begin
            mem_r[tail_s ^ push0_valid] <= push1_data;
        end
    end

    assign head_valid = (count_r != 2'd0);
    assign head_data  = mem_r[head_ptr_r];
    assign count      = count_r;

endmodule

// File: rtl/simple_hella_cache_if.sv
// Adapter between a simple blocking client and a nacking hella cache port.
// Tracks the s1/s2 pipeline and replays nacked requests in program order.
module simple_hella_cache_if
    import simple_hella_cache_if_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int TAG_W  = DEF_TAG_W
) (
    input logic clk,
    input logic reset,
    simple_hella_cache_if_if.slave bus
);
    localparam int REC_W    = req_rec_w(ADDR_W, TAG_W, DATA_W);
    localparam int PHYS_LSB = DATA_W;
    localparam int TYP_LSB  = PHYS_LSB + PHYS_W;
    localparam int CMD_LSB  = TYP_LSB + TYP_W;
    localparam int TAG_LSB  = CMD_LSB + CMD_W;
    localparam int ADDR_LSB = TAG_LSB + TAG_W;

    logic [REC_W-1:0] client_rec_s;
    logic [REC_W-1:0] head_rec_s;
    logic [REC_W-1:0] issue_rec_s;
    logic [REC_W-1:0] s1_rec_r;
    logic [REC_W-1:0] s2_rec_r;
    logic             s1_valid_r;
    logic             s2_valid_r;
    logic             head_valid_s;
    logic [1:0]       count_s;
    logic             nack_s;
    logic             kill_s;
    logic             req_valid_s;
    logic             fire_s;

    assign client_rec_s = {bus.io_client_req_bits_addr, bus.io_client_req_bits_tag,
                           bus.io_client_req_bits_cmd,  bus.io_client_req_bits_typ,
                           bus.io_client_req_bits_phys, bus.io_client_req_bits_data};

    // Issue selection. A client request is withheld in a nack cycle because the
    // client is not accepted then; letting it reach the cache would duplicate it.
    always_comb begin
        nack_s = s2_valid_r & bus.io_cache_s2_nack;
        kill_s = nack_s & s1_valid_r;
        if (head_valid_s) begin
            issue_rec_s = head_rec_s;
            req_valid_s = 1'b1;
        end else begin
            issue_rec_s = client_rec_s;
            req_valid_s = bus.io_client_req_valid & ~nack_s;
        end
        fire_s = req_valid_s & bus.io_cache_req_ready;
    end

    // Pipeline valid bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_r <= 1'b0;
            s2_valid_r <= 1'b0;
        end else begin
            s1_valid_r <= fire_s;
            s2_valid_r <= s1_valid_r & ~kill_s;
        end
    end

    // Pipeline payload; only the valid bits need reset.
    always_ff @(posedge clk) begin
        if (fire_s) begin
            s1_rec_r <= issue_rec_s;
        end
        s2_rec_r <= s1_rec_r;
    end

    hella_replay_queue #(.W(REC_W)) u_replay (
        .clk         (clk),
        .reset       (reset),
        .push0_valid (nack_s),
        .push0_data  (s2_rec_r),
        .push1_valid (kill_s),
        .push1_data  (s1_rec_r),
        .pop         (fire_s & head_valid_s),
        .head_valid  (head_valid_s),
        .head_data   (head_rec_s),
        .count       (count_s)
    );

    simple_hella_cache_if_chk u_chk (
        .clk      (clk),
        .reset    (reset),
        .count    (count_s),
        .s1_kill  (kill_s),
        .s1_valid (s1_valid_r)
    );

    assign bus.io_cache_req_valid     = req_valid_s;
    assign bus.io_cache_req_bits_addr = issue_rec_s[ADDR_LSB +: ADDR_W];
    assign bus.io_cache_req_bits_tag  = issue_rec_s[TAG_LSB +: TAG_W];
    assign bus.io_cache_req_bits_cmd  = issue_rec_s[CMD_LSB +: CMD_W];
    assign bus.io_cache_req_bits_typ  = issue_rec_s[TYP_LSB +: TYP_W];
    assign bus.io_cache_req_bits_phys = issue_rec_s[PHYS_LSB];
    assign bus.io_cache_s1_kill       = kill_s;
    assign bus.io_cache_s1_data       = s1_rec_r[DATA_W-1:0];

    assign bus.io_client_req_ready = bus.io_cache_req_ready & ~head_valid_s & ~nack_s;
    assign bus.io_client_busy      = s1_valid_r | s2_valid_r | (count_s != 2'd0);

    assign bus.io_client_resp_valid         = bus.io_cache_resp_valid & ~bus.io_cache_resp_bits_replay;
    assign bus.io_client_resp_bits_tag      = bus.io_cache_resp_bits_tag;
    assign bus.io_client_resp_bits_data     = bus.io_cache_resp_bits_data;
    assign bus.io_client_resp_bits_has_data = bus.io_cache_resp_bits_has_data;

endmodule

// File: tb/tb_simple_hella_cache_if.sv
// Bench for simple_hella_cache_if: directed scenarios followed by random traffic,
// checked against a queue-based model of in-flight and replayed requests.
module tb_simple_hella_cache_if;
    import simple_hella_cache_if_pkg::*;

    typedef struct packed {
        logic [31:0] addr;
        logic [8:0]  tag;
        logic [4:0]  cmd;
        logic [2:0]  typ;
        logic        phys;
        logic [31:0] data;
    } req_t;

    typedef struct packed {
        req_t r;
        int   age;
    } flight_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    simple_hella_cache_if_if #(.ADDR_W(32), .DATA_W(32), .TAG_W(9)) bus ();

    simple_hella_cache_if #(.ADDR_W(32), .DATA_W(32), .TAG_W(9)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    req_t        cli;
    logic        cli_valid, cache_ready, nack_in;
    logic        rsp_valid, rsp_replay, rsp_has_data;
    logic [8:0]  rsp_tag;
    logic [31:0] rsp_data;
    logic        cli_taken;

    assign bus.io_client_req_valid         = cli_valid;
    assign bus.io_client_req_bits_addr     = cli.addr;
    assign bus.io_client_req_bits_tag      = cli.tag;
    assign bus.io_client_req_bits_cmd      = cli.cmd;
    assign bus.io_client_req_bits_typ      = cli.typ;
    assign bus.io_client_req_bits_phys     = cli.phys;
    assign bus.io_client_req_bits_data     = cli.data;
    assign bus.io_cache_req_ready          = cache_ready;
    assign bus.io_cache_s2_nack            = nack_in;
    assign bus.io_cache_resp_valid         = rsp_valid;
    assign bus.io_cache_resp_bits_tag      = rsp_tag;
    assign bus.io_cache_resp_bits_data     = rsp_data;
    assign bus.io_cache_resp_bits_has_data = rsp_has_data;
    assign bus.io_cache_resp_bits_replay   = rsp_replay;

    // Model: replay list in age order, and fired requests tagged with cycles since fire.
    req_t    rq[$];
    flight_t fl[$];
    int      dut_log[$];
    int      n_tests = 0;
    int      n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic int find_age(input int a);
        foreach (fl[k]) if (fl[k].age == a) return k;
        return -1;
    endfunction

    function automatic req_t make_req(input logic [31:0] addr, input logic [8:0] tag,
                                      input logic [4:0] cmd, input logic [31:0] data);
        req_t r;
        r.addr = addr; r.tag = tag; r.cmd = cmd; r.typ = MT_W; r.phys = 1'b0; r.data = data;
        return r;
    endfunction

    task automatic idle();
        cli_valid = 1'b0; cache_ready = 1'b1; nack_in = 1'b0; reset = 1'b0;
        rsp_valid = 1'b0; rsp_replay = 1'b0; rsp_has_data = 1'b0;
        rsp_tag = 9'd0; rsp_data = 32'd0;
    endtask

    // Check the current cycle against the model, then advance one clock.
    task automatic step();
        int      i1, i2;
        logic    nack_eff, head, exp_valid, exp_ready, fire;
        req_t    exp_bits, fired;
        flight_t e;
        flight_t nf[$];
        #1;
        i1 = find_age(1);
        i2 = find_age(2);
        nack_eff  = (i2 >= 0) && nack_in;
        head      = (rq.size() != 0);
        exp_valid = head || (cli_valid && !nack_eff);
        exp_ready = cache_ready && !head && !nack_eff;
        if (!reset) begin
            check_eq("cache_req_valid", bus.io_cache_req_valid, exp_valid);
            if (exp_valid) begin
                exp_bits = head ? rq[0] : cli;
                check_eq("cache_req_bits",
                    {bus.io_cache_req_bits_addr, bus.io_cache_req_bits_tag, bus.io_cache_req_bits_cmd,
                     bus.io_cache_req_bits_typ, bus.io_cache_req_bits_phys},
                    {exp_bits.addr, exp_bits.tag, exp_bits.cmd, exp_bits.typ, exp_bits.phys});
            end
            check_eq("client_req_ready", bus.io_client_req_ready, exp_ready);
            check_eq("s1_kill", bus.io_cache_s1_kill, nack_eff && (i1 >= 0));
            check_eq("client_busy", bus.io_client_busy, (fl.size() != 0) || head);
            if (i1 >= 0) check_eq("s1_data", bus.io_cache_s1_data, fl[i1].r.data);
            check_eq("client_resp_valid", bus.io_client_resp_valid, rsp_valid && !rsp_replay);
            check_eq("client_resp_bits",
                {bus.io_client_resp_bits_tag, bus.io_client_resp_bits_data, bus.io_client_resp_bits_has_data},
                {rsp_tag, rsp_data, rsp_has_data});
            if (bus.io_cache_req_valid === 1'b1 && cache_ready)
                dut_log.push_back(int'(bus.io_cache_req_bits_tag));
        end
        @(posedge clk);
        cli_taken = 1'b0;
        if (reset) begin
            rq.delete();
            fl.delete();
        end else begin
            fire = exp_valid && cache_ready;
            cli_taken = fire && !head;
            fired = '0;
            if (fire) fired = head ? rq.pop_front() : cli;
            if (nack_eff) begin
                rq.push_back(fl[i2].r);
                if (i1 >= 0) rq.push_back(fl[i1].r);
                fl.delete();
            end else begin
                foreach (fl[k]) begin
                    if (fl[k].age < 2) begin
                        e = fl[k];
                        e.age = e.age + 1;
                        nf.push_back(e);
                    end
                end
                fl = nf;
            end
            if (fire) begin
                e.r = fired;
                e.age = 1;
                fl.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    int exp_tags[6] = '{1, 2, 1, 2, 1, 2};

    initial begin
        cli = '0;
        cli_taken = 1'b0;
        idle();
        reset = 1'b1;
        @(negedge clk);
        step();
        step();
        reset = 1'b0;
        check_eq("reset_req_valid", bus.io_cache_req_valid, 1'b0);
        check_eq("reset_busy", bus.io_client_busy, 1'b0);
        check_eq("reset_kill", bus.io_cache_s1_kill, 1'b0);

        // Single load, response forwarded while it sits in s2.
        cli = make_req(32'h1000, 9'h05, M_XRD, 32'h0);
        cli_valid = 1'b1;
        step();
        check_eq("load_taken", cli_taken, 1'b1);
        cli_valid = 1'b0;
        step();
        rsp_valid = 1'b1; rsp_tag = 9'h05; rsp_data = 32'h1234_5678; rsp_has_data = 1'b1;
        step();
        check_eq("load_resp_tag", bus.io_client_resp_bits_tag, 9'h05);
        rsp_valid = 1'b0;
        step();
        step();
        check_eq("load_busy_clear", bus.io_client_busy, 1'b0);

        // Store data appears on s1_data one cycle after fire.
        cli = make_req(32'h2000, 9'h06, M_XWR, 32'hDEAD_BEEF);
        cli_valid = 1'b1;
        step();
        cli_valid = 1'b0;
        check_eq("store_s1_data", bus.io_cache_s1_data, 32'hDEAD_BEEF);
        repeat (3) step();

        // Back-to-back loads, nack of tag 1, replay, second nack, replay again.
        dut_log.delete();
        cli = make_req(32'h3000, 9'd1, M_XRD, 32'h0); cli_valid = 1'b1;
        step();
        cli = make_req(32'h3004, 9'd2, M_XRD, 32'h0);
        step();
        cli_valid = 1'b0; nack_in = 1'b1;
        step();
        nack_in = 1'b0;
        check_eq("ready_low_replay", bus.io_client_req_ready, 1'b0);
        step();
        step();
        nack_in = 1'b1;
        step();
        nack_in = 1'b0;
        repeat (4) step();
        check_eq("replay_log_len", dut_log.size(), 6);
        for (int i = 0; i < 6 && i < dut_log.size(); i++)
            check_eq("replay_order", dut_log[i], exp_tags[i]);

        // Replay-flagged response hidden; stalled cache port never fires.
        rsp_valid = 1'b1; rsp_replay = 1'b1; rsp_tag = 9'h33;
        step();
        rsp_valid = 1'b0; rsp_replay = 1'b0;
        cache_ready = 1'b0;
        cli = make_req(32'h4000, 9'h44, M_XRD, 32'h0); cli_valid = 1'b1;
        repeat (5) step();
        check_eq("stall_busy", bus.io_client_busy, 1'b0);
        cache_ready = 1'b1;
        step();
        cli_valid = 1'b0;
        repeat (3) step();

        // Reset with two buffered entries drops them.
        cli = make_req(32'h5000, 9'd7, M_XRD, 32'h0); cli_valid = 1'b1;
        step();
        cli = make_req(32'h5004, 9'd8, M_XRD, 32'h0);
        step();
        cli_valid = 1'b0; nack_in = 1'b1; cache_ready = 1'b0;
        step();
        nack_in = 1'b0;
        check_eq("buffered_busy", bus.io_client_busy, 1'b1);
        reset = 1'b1;
        step();
        reset = 1'b0; cache_ready = 1'b1;
        check_eq("post_reset_req_valid", bus.io_cache_req_valid, 1'b0);
        check_eq("post_reset_busy", bus.io_client_busy, 1'b0);
        repeat (3) step();

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            if (!cli_valid && $urandom_range(0, 9) < 6) begin
                cli = make_req($urandom, 9'($urandom_range(0, 511)),
                               ($urandom_range(0, 1) == 1) ? M_XWR : M_XRD, $urandom);
                cli.phys = 1'($urandom_range(0, 1));
                cli_valid = 1'b1;
            end
            cache_ready  = ($urandom_range(0, 9) < 8);
            nack_in      = ($urandom_range(0, 3) == 0);
            rsp_valid    = ($urandom_range(0, 1) == 1);
            rsp_replay   = ($urandom_range(0, 2) == 0);
            rsp_has_data = 1'($urandom_range(0, 1));
            rsp_tag      = 9'($urandom_range(0, 511));
            rsp_data     = $urandom;
            reset        = ($urandom_range(0, 199) == 0);
            step();
            if (cli_taken) cli_valid = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
